// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port data-memory arbiter.
package mem_arb_pkg;

  localparam int WORD_W = 32;

  localparam int PORT0 = 0;
  localparam int PORT1 = 1;

  // Word accesses only: any set bit under this mask marks a misaligned address.
  localparam logic [WORD_W-1:0] ALIGN_MASK = 32'h0000_0003;

  function automatic logic is_aligned(input logic [WORD_W-1:0] addr);
    return (addr & ALIGN_MASK) == '0;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester grant logic: round-robin on contention, or port 0 always
// wins when PRIO_FIXED is set. Grants are combinational and forced low in reset.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1
);

  localparam logic LAST_IS_P1 = 1'(PORT1);

  // 1 when port 1 won the most recent accepted transfer.
  logic r_last_grant;
  logic w_gnt0;
  logic w_gnt1;

  // Pick a winner; on contention favour the port that did not win last.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (!reset) begin
      if (req0 && req1) begin
        if ((PRIO_FIXED != 0) || (r_last_grant == LAST_IS_P1)) begin
          w_gnt0 = 1'b1;
        end else begin
          w_gnt1 = 1'b1;
        end
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  // Remember the winner only when a transfer actually happens.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= LAST_IS_P1;
    end else if (w_gnt0 || w_gnt1) begin
      r_last_grant <= w_gnt1;
    end
  end

  assign gnt0 = w_gnt0;
  assign gnt1 = w_gnt1;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port front end to a single-ported data memory: arbitrates requests,
// muxes the winner onto the memory bus, returns one-cycle-latency responses
// and keeps saturating per-port accept counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int PRIO_FIXED = 0,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [WORD_W-1:0] req0_addr,
  input  logic [WORD_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [WORD_W-1:0] req1_addr,
  input  logic [WORD_W-1:0] req1_wdata,
  output logic              req0_ready,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [WORD_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  output logic [WORD_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  output logic [WORD_W-1:0] mem_address,
  output logic              mem_writeEnable,
  output logic [WORD_W-1:0] mem_dataIn,
  input  logic [WORD_W-1:0] mem_dataOut,
  output logic [CNT_W-1:0]  grant_cnt0,
  output logic [CNT_W-1:0]  grant_cnt1
);

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_sel_write;
  logic [WORD_W-1:0] w_sel_addr;
  logic [WORD_W-1:0] w_sel_wdata;
  logic              w_aligned;
  logic [WORD_W-1:0] w_load_data;

  logic              r_rsp0_valid;
  logic [WORD_W-1:0] r_rsp0_rdata;
  logic              r_rsp0_err;
  logic              r_rsp1_valid;
  logic [WORD_W-1:0] r_rsp1_rdata;
  logic              r_rsp1_err;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    return (cnt == '1) ? cnt : cnt + 1'b1;
  endfunction

  rr_arb2 #(
    .PRIO_FIXED(PRIO_FIXED)
  ) u_arb (
    .clk  (clk),
    .reset(reset),
    .req0 (req0_valid),
    .req1 (req1_valid),
    .gnt0 (w_gnt0),
    .gnt1 (w_gnt1)
  );

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign w_any      = w_gnt0 | w_gnt1;

  // Route the granted request onto the memory bus; idle bus is all zeros.
  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_gnt0) begin
      w_sel_write = req0_write;
      w_sel_addr  = req0_addr;
      w_sel_wdata = req0_wdata;
    end else if (w_gnt1) begin
      w_sel_write = req1_write;
      w_sel_addr  = req1_addr;
      w_sel_wdata = req1_wdata;
    end
  end

  assign w_aligned       = is_aligned(w_sel_addr);
  assign mem_address     = w_sel_addr;
  assign mem_dataIn      = w_sel_wdata;
  // Misaligned stores are accepted but must never reach the memory.
  assign mem_writeEnable = w_any && w_sel_write && w_aligned;
  // Only aligned loads return memory contents; stores and errors return 0.
  assign w_load_data     = (w_any && !w_sel_write && w_aligned) ? mem_dataOut : '0;

  // Capture the response of this cycle's accept for presentation next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_rdata <= '0;
      r_rsp0_err   <= 1'b0;
      r_rsp1_valid <= 1'b0;
      r_rsp1_rdata <= '0;
      r_rsp1_err   <= 1'b0;
    end else begin
      r_rsp0_valid <= w_gnt0;
      r_rsp0_rdata <= w_gnt0 ? w_load_data : '0;
      r_rsp0_err   <= w_gnt0 && !w_aligned;
      r_rsp1_valid <= w_gnt1;
      r_rsp1_rdata <= w_gnt1 ? w_load_data : '0;
      r_rsp1_err   <= w_gnt1 && !w_aligned;
    end
  end

  // Count accepted transfers per port, holding at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_gnt0) r_cnt0 <= sat_inc(r_cnt0);
      if (w_gnt1) r_cnt1 <= sat_inc(r_cnt1);
    end
  end

  // A response registered just before reset rises must not leak out while
  // reset is held, so outputs are also masked by reset directly.
  assign rsp0_valid = r_rsp0_valid & ~reset;
  assign rsp0_rdata = reset ? '0 : r_rsp0_rdata;
  assign rsp0_err   = r_rsp0_err & ~reset;
  assign rsp1_valid = r_rsp1_valid & ~reset;
  assign rsp1_rdata = reset ? '0 : r_rsp1_rdata;
  assign rsp1_err   = r_rsp1_err & ~reset;
  assign grant_cnt0 = reset ? '0 : r_cnt0;
  assign grant_cnt1 = reset ? '0 : r_cnt1;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameter: PRIO_FIXED, 0, 0 = round-robin, 1 = port 0 always wins.
REQ-002 Parameter: CNT_W, 16, width of per-port grant counters.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0_valid / req1_valid  input  1  requester N presents an access.
REQ-006 req0_write / req1_write  input  1  1 = store, 0 = load.
REQ-007 req0_addr / req1_addr  input  32  byte address.
REQ-008 req0_wdata / req1_wdata  input  32  store data.
REQ-009 req0_ready / req1_ready  output  1  combinational grant; transfer occurs when valid && ready at posedge.
REQ-010 rsp0_valid / rsp1_valid  output  1  one-cycle pulse completing an accepted access.
REQ-011 rsp0_rdata / rsp1_rdata  output  32  load data; 0 for stores and errors.
REQ-012 rsp0_err / rsp1_err  output  1  accepted access was misaligned (addr[1:0] != 0).
REQ-013 mem_address  output  32  address to the data memory.
REQ-014 mem_writeEnable  output  1  memory write strobe, sampled by the memory at posedge clk.
REQ-015 mem_dataIn  output  32  memory write data.
REQ-016 mem_dataOut  input  32  memory read data, combinational from mem_address.
REQ-017 grant_cnt0 / grant_cnt1  output  CNT_W  accepted-access counters.

Function
- REQ-018 At most one ready is high per cycle; ready is never high without the matching valid.
- REQ-019 Only one valid: that port is granted.
- REQ-020 Both valid, PRIO_FIXED=0: grant the port not granted last; last_grant updates only on an accepted transfer.
- REQ-021 Both valid, PRIO_FIXED=1: port 0 is granted.
- REQ-022 Granted port's addr/wdata drive mem_address/mem_dataIn in the same cycle.
- REQ-023 mem_writeEnable = granted && write && addr[1:0]==0.
- REQ-024 No grant: mem_writeEnable = 0, mem_address and mem_dataIn = 0.
- REQ-025 Load latency is 1 cycle: mem_dataOut is registered at the accepting edge; rspN_valid=1 and rspN_rdata are presented in the following cycle.
- REQ-026 Store: rspN_valid pulses in the following cycle with rdata = 0.
- REQ-027 Misaligned access: accepted and not written; rsp err = 1, rdata = 0 in the following cycle.
- REQ-028 Back-to-back accepts on the same or alternating ports are allowed every cycle (full throughput).
- REQ-029 Responses of successive accesses never merge or drop.
- REQ-030 Load to an address the same port stored in the prior cycle returns the new data, because the memory write completes at that edge.
- REQ-031 grant_cntN increments by 1 per accepted transfer.
- REQ-032 grant_cntN saturates at all-ones and does not wrap.
- REQ-033 A requester must hold valid, write, addr and wdata stable until accepted; the arbiter does not rely on valid dropping.

Reset
- REQ-034 While reset=1: ready=0, mem_writeEnable=0, rsp*_valid=0, rsp*_rdata=0, rsp*_err=0, grant_cnt*=0.
- REQ-035 While reset=1: last_grant=1, so port 0 wins the first contended cycle.
- REQ-036 Reset asserted in the cycle after an accept suppresses that pending response; no response is emitted after reset.
- REQ-037 Reset asserted in the same cycle as valid && ready-eligible produces no memory write.

Structure
- REQ-038 Package mem_arb_pkg holds: port index constants (PORT0=0, PORT1=1), the address-alignment mask constant, and the word width (32).
- REQ-039 Sub-module rr_arb2 (two-input round-robin grant with last_grant register and PRIO_FIXED override) is instantiated once; the datapath mux, response registers and counters live in mem_port_arbiter.

Verification
- REQ-040 Port 0 stores 0xDEADBEEF to 0x10, then loads 0x10 -> rsp0_valid one cycle after each accept; load rdata = 0xDEADBEEF; grant_cnt0 = 2.
- REQ-041 Both ports load continuously for 6 cycles, PRIO_FIXED=0 -> grants alternate 0,1,0,1,0,1 starting at port 0; each counter = 3.
- REQ-042 Same stimulus, PRIO_FIXED=1 -> port 0 granted all 6 cycles; port 1 ready stays 0; grant_cnt1 = 0.
- REQ-043 Port 1 stores 0x12345678 to address 0x13 -> mem_writeEnable stays 0; rsp1_err = 1, rdata = 0; a following load of 0x10 is unchanged.
- REQ-044 Assert reset in the cycle after a port-0 load accept -> no rsp0_valid; counters 0; next contended grant goes to port 0.
- REQ-045 CNT_W=4, 20 port-0 accesses -> grant_cnt0 holds at 15.
